// File: rtl/kernel.sv
// Sliding-window kernel: accepts one pixel column per transfer and presents a
// BLOCK_HEIGHT x BLOCK_WIDTH window that advances with stride one.
module kernel #(
   parameter int DATA_WIDTH   = 8,
   parameter int BLOCK_HEIGHT = 3,
   parameter int BLOCK_WIDTH  = 3,
   localparam int INPUT_WIDTH  = DATA_WIDTH * BLOCK_HEIGHT,
   localparam int OUTPUT_WIDTH = BLOCK_WIDTH * BLOCK_HEIGHT * DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INPUT_WIDTH-1:0]  in_pixels,
   input  logic [BLOCK_HEIGHT-1:0] in_valid,
   output logic [BLOCK_HEIGHT-1:0] in_ready,
   output logic [OUTPUT_WIDTH-1:0] out_pixels,
   output logic [BLOCK_HEIGHT-1:0] out_valid,
   input  logic [BLOCK_HEIGHT-1:0] out_ready,
   output logic                    kernel_valid
);

   localparam int CNT_W = $clog2(BLOCK_WIDTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_WIDTH);

   logic [OUTPUT_WIDTH-1:0] r_window;
   logic [CNT_W-1:0]        r_cnt;
   logic [OUTPUT_WIDTH-1:0] w_nextWindow;
   logic                    w_full;
   logic                    w_space;
   logic                    w_inFire;
   logic                    w_outFire;

   assign w_full    = (r_cnt == FULL);
   assign w_outFire = w_full & (&out_ready);
   assign w_space   = ~w_full | (&out_ready);
   // A column moves only when every row lane offers a pixel at once.
   assign w_inFire  = (&in_valid) & w_space & ~rst;

   assign in_ready     = {BLOCK_HEIGHT{w_inFire}};
   assign kernel_valid = w_full;
   assign out_valid    = {BLOCK_HEIGHT{w_full}};
   assign out_pixels   = r_window;

   genvar gr, gc;
   generate
      for (gr = 0; gr < BLOCK_HEIGHT; gr++) begin : g_row
         for (gc = 0; gc < BLOCK_WIDTH; gc++) begin : g_col
            if (gc == BLOCK_WIDTH - 1) begin : g_newest
               assign w_nextWindow[(gr*BLOCK_WIDTH+gc)*DATA_WIDTH +: DATA_WIDTH] =
                  in_pixels[gr*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_shift
               assign w_nextWindow[(gr*BLOCK_WIDTH+gc)*DATA_WIDTH +: DATA_WIDTH] =
                  r_window[(gr*BLOCK_WIDTH+gc+1)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_window <= '0;
      end else if (w_inFire) begin
         r_window <= w_nextWindow;
      end
   end

   // Consuming a window leaves the last BLOCK_WIDTH-1 columns as the start of
   // the next one, so a drain without refill drops to FULL-1 rather than zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case ({w_inFire, w_outFire})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= FULL - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel.sv
// Self-checking bench for kernel: directed scenarios followed by random
// traffic, compared against a column-history reference model.
module tb_kernel;

   localparam int DW = 8;
   localparam int BH = 3;
   localparam int BW = 3;
   localparam int IW = DW * BH;
   localparam int OW = DW * BH * BW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [IW-1:0] in_pixels = '0;
   logic [BH-1:0] in_valid = '0;
   logic [BH-1:0] in_ready;
   logic [OW-1:0] out_pixels;
   logic [BH-1:0] out_valid;
   logic [BH-1:0] out_ready = '0;
   logic          kernel_valid;

   int total = 0;
   int bad = 0;

   // Model: every accepted column since reset (seeded with zero columns) and
   // how many columns of the current window are still unconsumed.
   logic [IW-1:0] hist[$];
   int            mCount = 0;
   bit            mInit = 0;

   kernel #(.DATA_WIDTH(DW), .BLOCK_HEIGHT(BH), .BLOCK_WIDTH(BW)) dut (
      .clk(clk),
      .rst(rst),
      .in_pixels(in_pixels),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_pixels(out_pixels),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .kernel_valid(kernel_valid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [OW-1:0] modelWindow();
      logic [OW-1:0] w;
      logic [IW-1:0] col;
      w = '0;
      for (int c = 0; c < BW; c++) begin
         col = hist[hist.size() - BW + c];
         for (int r = 0; r < BH; r++)
            w[(r*BW+c)*DW +: DW] = col[r*DW +: DW];
      end
      return w;
   endfunction

   task automatic modelReset();
      hist.delete();
      for (int i = 0; i < BW; i++) hist.push_back('0);
      mCount = 0;
      mInit = 1;
   endtask

   // One clock cycle: drive at the falling edge, check just after, then
   // advance the model by what the rising edge should do.
   task automatic applyStimulus(input logic rstIn, input logic [BH-1:0] v,
                                input logic [BH-1:0] rdy, input logic [IW-1:0] px);
      bit full, takeIn, takeOut;
      @(negedge clk);
      rst = rstIn;
      in_valid = v;
      out_ready = rdy;
      in_pixels = px;
      #1;
      full    = mInit && (mCount == BW);
      takeIn  = !rstIn && mInit && (&v) && (!full || (&rdy));
      takeOut = !rstIn && full && (&rdy);
      checkOutput("in_ready", 128'(in_ready), 128'({BH{takeIn}}));
      if (mInit) begin
         checkOutput("kernel_valid", 128'(kernel_valid), 128'(full));
         checkOutput("out_valid", 128'(out_valid), 128'({BH{full}}));
         checkOutput("out_pixels", 128'(out_pixels), 128'(modelWindow()));
      end
      if (rstIn) begin
         modelReset();
      end else begin
         if (takeIn) begin
            hist.push_back(px);
            if (hist.size() > BW) void'(hist.pop_front());
         end
         if (takeOut && !takeIn) mCount = BW - 1;
         else if (takeIn && !takeOut) mCount = mCount + 1;
      end
   endtask

   initial begin
      logic [IW-1:0] px;
      logic [BH-1:0] v, rdy;

      applyStimulus(1'b1, '1, '1, 24'hFFFFFF);
      applyStimulus(1'b1, '1, '1, 24'hFFFFFF);

      // Three columns fill the first window; row r reads {C_r,B_r,A_r}.
      applyStimulus(1'b0, 3'b111, 3'b111, 24'h231301);
      applyStimulus(1'b0, 3'b111, 3'b111, 24'h241402);
      applyStimulus(1'b0, 3'b111, 3'b000, 24'h251503);
      @(posedge clk);
      #1;
      checkOutput("first_window", 128'(out_pixels), 128'(72'h252423_151413_030201));
      checkOutput("first_valid", 128'(kernel_valid), 128'(1'b1));

      // Downstream partially stalled: everything must hold.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 3'b111, 3'b110, 24'(32'hA0A0A0 + i));

      // Continuous streaming.
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 3'b111, 3'b111, 24'($urandom));

      // A missing row lane blocks the column.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 3'b110, 3'b111, 24'($urandom));

      // Drain without refill, then a single column restores a full window.
      applyStimulus(1'b0, 3'b101, 3'b111, 24'h777777);
      applyStimulus(1'b0, 3'b111, 3'b111, 24'h343434);
      applyStimulus(1'b0, 3'b000, 3'b000, 24'h0);

      // Reset with a full window held, then refill.
      applyStimulus(1'b1, 3'b111, 3'b111, 24'h121212);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 3'b111, 3'b111, 24'($urandom));

      // Random traffic biased toward complete handshakes.
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom);
         rdy = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom);
         px  = 24'($urandom);
         applyStimulus(($urandom_range(0, 60) == 0), v, rdy, px);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
